// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//
// MEM-stage consumer of the EX/MEM pipeline register. A load or store coming
// out of EX is turned into a single req/gnt/rvalid transaction on the data
// bus. Store data is replicated across byte lanes with matching byte
// enables; load data is shifted down from its lane and sign- or
// zero-extended. Writeback outputs are registered. While a bus access is
// outstanding the upstream pipeline is frozen through stall_req.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   rd_in          ALU result: address for load/store, writeback data otherwise
//   rd_en_in       writeback enable of the instruction in EX/MEM
//   rd_addr_in     destination register of the instruction in EX/MEM
//   load_flag_in   one-hot {LHU,LBU,LW,LH,LB}, 0 = no load
//   store_flag_in  one-hot {SW,SH,SB}, 0 = no store
//   store_data_in  rs2 value for stores
//   mem_req        bus request, held until mem_gnt
//   mem_we         1 = write transaction
//   mem_addr       word-aligned bus address
//   mem_be         byte enables
//   mem_wdata      lane-replicated store data
//   mem_gnt        request accepted this cycle
//   mem_rvalid     read data valid
//   mem_rdata      read data word
//   wb_data        registered writeback data
//   wb_en          registered writeback enable
//   wb_addr        registered writeback register
//   stall_req      freeze upstream while an access is in flight
//   misalign_exc   one-cycle pulse: misaligned access, no bus activity
//   bus_err        one-cycle pulse: access aborted by timeout
// ---------------------------------------------------------------------------
module mem_access_unit #(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   rd_in,
  input  logic              rd_en_in,
  input  logic [REG_AW-1:0] rd_addr_in,
  input  logic [4:0]        load_flag_in,
  input  logic [2:0]        store_flag_in,
  input  logic [XLEN-1:0]   store_data_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [3:0]        mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic [XLEN-1:0]   wb_data,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_addr,
  output logic              stall_req,
  output logic              misalign_exc,
  output logic              bus_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  // Decoded operation of the instruction currently presented by EX/MEM
  logic is_lb, is_lh, is_lw, is_lbu, is_lhu;
  logic is_sb, is_sh, is_sw;
  logic is_load, is_store, is_mem;
  logic misaligned;
  logic start_access;

  // Lane-formatted request for the presented instruction
  logic [3:0]      be_next;
  logic [XLEN-1:0] wdata_next;

  // Request latched for the duration of the access
  logic [XLEN-1:0]   addr_q;
  logic [3:0]        be_q;
  logic [XLEN-1:0]   wdata_q;
  logic              we_q;
  logic [4:0]        ld_kind_q;
  logic [1:0]        off_q;
  logic [REG_AW-1:0] rd_addr_q;
  logic              rd_en_q;

  logic [TO_W-1:0] to_cnt;
  logic            timeout_hit;

  logic [XLEN-1:0] rdata_shifted;
  logic [XLEN-1:0] load_ext;

  logic wb_en_q;
  logic misalign_q;
  logic bus_err_q;

  // Flags are expected one-hot, but a malformed encoding must still decode
  // to exactly one operation: lowest set bit wins and any load outranks any
  // store.
  always_comb begin
    is_lb  = 1'b0;
    is_lh  = 1'b0;
    is_lw  = 1'b0;
    is_lbu = 1'b0;
    is_lhu = 1'b0;
    is_sb  = 1'b0;
    is_sh  = 1'b0;
    is_sw  = 1'b0;
    if (load_flag_in[0])       is_lb  = 1'b1;
    else if (load_flag_in[1])  is_lh  = 1'b1;
    else if (load_flag_in[2])  is_lw  = 1'b1;
    else if (load_flag_in[3])  is_lbu = 1'b1;
    else if (load_flag_in[4])  is_lhu = 1'b1;
    else if (store_flag_in[0]) is_sb  = 1'b1;
    else if (store_flag_in[1]) is_sh  = 1'b1;
    else if (store_flag_in[2]) is_sw  = 1'b1;
  end

  assign is_load  = is_lb | is_lh | is_lw | is_lbu | is_lhu;
  assign is_store = is_sb | is_sh | is_sw;
  assign is_mem   = is_load | is_store;

  assign misaligned = ((is_lh | is_lhu | is_sh) & rd_in[0]) |
                      ((is_lw | is_sw) & (rd_in[1:0] != 2'b00));

  assign start_access = is_mem & ~misaligned;

  // Byte enables follow the access width for loads as well as stores so the
  // bus sees which lanes the load actually consumes.
  always_comb begin
    be_next    = 4'b0000;
    wdata_next = '0;
    if (is_sb || is_lb || is_lbu) begin
      be_next    = 4'b0001 << rd_in[1:0];
      wdata_next = {4{store_data_in[7:0]}};
    end else if (is_sh || is_lh || is_lhu) begin
      be_next    = rd_in[1] ? 4'b1100 : 4'b0011;
      wdata_next = {2{store_data_in[15:0]}};
    end else if (is_sw || is_lw) begin
      be_next    = 4'b1111;
      wdata_next = store_data_in;
    end
    if (!is_store) begin
      wdata_next = '0;
    end
  end

  assign timeout_hit = (to_cnt == TO_W'(TIMEOUT));

  // Load data extraction from the lane selected by the latched byte offset
  assign rdata_shifted = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    load_ext = rdata_shifted;
    if (ld_kind_q[0])      load_ext = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
    else if (ld_kind_q[1]) load_ext = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
    else if (ld_kind_q[2]) load_ext = mem_rdata;
    else if (ld_kind_q[3]) load_ext = {24'h000000, rdata_shifted[7:0]};
    else if (ld_kind_q[4]) load_ext = {16'h0000, rdata_shifted[15:0]};
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic; the timeout abort takes priority over a late
  // gnt/rvalid arriving in the same cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start_access) next_state = REQ;
      end
      REQ: begin
        if (timeout_hit)  next_state = IDLE;
        else if (mem_gnt) next_state = we_q ? DONE : WAIT_R;
      end
      WAIT_R: begin
        if (timeout_hit)     next_state = IDLE;
        else if (mem_rvalid) next_state = DONE;
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // FSM outputs. In the abort cycle both the request and the stall drop so
  // the upstream pipeline moves past the failed instruction instead of
  // re-issuing it from IDLE. Stall is also masked during reset so every
  // output is quiet while rst is held.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    stall_req = 1'b0;
    case (state)
      IDLE: begin
        stall_req = start_access;
      end
      REQ: begin
        mem_req   = ~timeout_hit;
        mem_we    = we_q & ~timeout_hit;
        stall_req = ~timeout_hit;
      end
      WAIT_R: begin
        stall_req = ~timeout_hit;
      end
      DONE: begin
        stall_req = 1'b0;
      end
      default: begin
        stall_req = 1'b0;
      end
    endcase
    if (rst) begin
      stall_req = 1'b0;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;

  // Wait counter: restarts on every state change, so it measures the time
  // spent in the current waiting state only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (next_state != state) begin
      to_cnt <= '0;
    end else if ((state == REQ || state == WAIT_R) && !timeout_hit) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  // Request latch, captured once when an aligned access leaves IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      be_q      <= 4'b0000;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      ld_kind_q <= 5'b00000;
      off_q     <= 2'b00;
      rd_addr_q <= '0;
      rd_en_q   <= 1'b0;
    end else if (state == IDLE && start_access) begin
      addr_q    <= {rd_in[XLEN-1:2], 2'b00};
      be_q      <= be_next;
      wdata_q   <= wdata_next;
      we_q      <= is_store;
      ld_kind_q <= {is_lhu, is_lbu, is_lw, is_lh, is_lb};
      off_q     <= rd_in[1:0];
      rd_addr_q <= rd_addr_in;
      rd_en_q   <= rd_en_in;
    end
  end

  // Writeback and exception pulses. Non-memory ops pass straight through
  // from IDLE; a load retires its data on the rvalid edge so it is visible
  // in DONE; everything else leaves wb_en low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_data    <= '0;
      wb_en_q    <= 1'b0;
      wb_addr    <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      misalign_q <= (state == IDLE) && is_mem && misaligned;
      bus_err_q  <= (state == REQ || state == WAIT_R) && timeout_hit;
      wb_en_q    <= 1'b0;
      case (state)
        IDLE: begin
          if (!is_mem) begin
            wb_data <= rd_in;
            wb_en_q <= rd_en_in;
            wb_addr <= rd_addr_in;
          end
        end
        WAIT_R: begin
          if (mem_rvalid && !timeout_hit) begin
            wb_data <= load_ext;
            wb_en_q <= rd_en_q;
            wb_addr <= rd_addr_q;
          end
        end
        default: begin
          wb_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign wb_en        = wb_en_q;
  assign misalign_exc = misalign_q;
  assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
//
// Directed bench for mem_access_unit: ALU passthrough, byte/half loads with
// extension, lane-replicated stores, misaligned access, bus timeout and
// reset in the middle of a load.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

  localparam int TIMEOUT = 255;

  logic        clk;
  logic        rst;
  logic [31:0] rd_in;
  logic        rd_en_in;
  logic [4:0]  rd_addr_in;
  logic [4:0]  load_flag_in;
  logic [2:0]  store_flag_in;
  logic [31:0] store_data_in;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] wb_data;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic        stall_req;
  logic        misalign_exc;
  logic        bus_err;

  int errors;
  int checks;
  int req_cycles;

  mem_access_unit #(
    .XLEN(32), .REG_AW(5), .TIMEOUT(TIMEOUT), .TO_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rd_in(rd_in),
    .rd_en_in(rd_en_in),
    .rd_addr_in(rd_addr_in),
    .load_flag_in(load_flag_in),
    .store_flag_in(store_flag_in),
    .store_data_in(store_data_in),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_be(mem_be),
    .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .wb_data(wb_data),
    .wb_en(wb_en),
    .wb_addr(wb_addr),
    .stall_req(stall_req),
    .misalign_exc(misalign_exc),
    .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; settle after the edge so sampling is away from it
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [31:0] rd, input logic rd_en,
                               input logic [4:0] rd_addr, input logic [4:0] ld,
                               input logic [2:0] st, input logic [31:0] sdata);
    rd_in         = rd;
    rd_en_in      = rd_en;
    rd_addr_in    = rd_addr;
    load_flag_in  = ld;
    store_flag_in = st;
    store_data_in = sdata;
    #1;
  endtask

  task automatic applyNop();
    applyStimulus(32'h0, 1'b0, 5'd0, 5'b00000, 3'b000, 32'h0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    rst        = 1'b1;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    applyNop();

    // Reset state
    tick();
    tick();
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_stall", stall_req, 0);
    checkOutput("rst_wb_en", wb_en, 0);
    checkOutput("rst_wb_data", wb_data, 32'h0);
    checkOutput("rst_misalign", misalign_exc, 0);
    checkOutput("rst_bus_err", bus_err, 0);
    rst = 1'b0;
    tick();

    // ALU passthrough
    $display("[TB] ALU passthrough");
    applyStimulus(32'h0000_1234, 1'b1, 5'd5, 5'b00000, 3'b000, 32'h0);
    checkOutput("alu_no_stall", stall_req, 0);
    tick();
    checkOutput("alu_wb_data", wb_data, 32'h0000_1234);
    checkOutput("alu_wb_en", wb_en, 1);
    checkOutput("alu_wb_addr", wb_addr, 5);
    applyNop();
    tick();
    checkOutput("nop_wb_en", wb_en, 0);

    // LB from lane 3, gnt in the first request cycle, rvalid two cycles later
    $display("[TB] LB with sign extension");
    applyStimulus(32'h0000_0103, 1'b1, 5'd7, 5'b00001, 3'b000, 32'h0);
    checkOutput("lb_idle_stall", stall_req, 1);
    checkOutput("lb_idle_req", mem_req, 0);
    mem_gnt = 1'b1;
    tick();
    checkOutput("lb_req", mem_req, 1);
    checkOutput("lb_we", mem_we, 0);
    checkOutput("lb_addr", mem_addr, 32'h0000_0100);
    tick();
    mem_gnt = 1'b0;
    checkOutput("lb_wait_req", mem_req, 0);
    checkOutput("lb_wait_stall", stall_req, 1);
    tick();
    checkOutput("lb_wait2_stall", stall_req, 1);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h80FF_FF7F;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    checkOutput("lb_wb_data", wb_data, 32'hFFFF_FF80);
    checkOutput("lb_wb_en", wb_en, 1);
    checkOutput("lb_wb_addr", wb_addr, 7);
    checkOutput("lb_done_stall", stall_req, 0);
    applyNop();
    tick();
    checkOutput("lb_after_wb_en", wb_en, 0);
    checkOutput("lb_after_stall", stall_req, 0);

    // SH to upper half, gnt after three request cycles
    $display("[TB] SH lane replication");
    applyStimulus(32'h0000_0202, 1'b0, 5'd0, 5'b00000, 3'b010, 32'h0000_ABCD);
    tick();
    checkOutput("sh_req", mem_req, 1);
    checkOutput("sh_we", mem_we, 1);
    checkOutput("sh_addr", mem_addr, 32'h0000_0200);
    checkOutput("sh_be", mem_be, 4'b1100);
    checkOutput("sh_wdata", mem_wdata, 32'hABCD_ABCD);
    checkOutput("sh_stall", stall_req, 1);
    tick();
    tick();
    checkOutput("sh_req_held", mem_req, 1);
    checkOutput("sh_be_held", mem_be, 4'b1100);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    checkOutput("sh_done_req", mem_req, 0);
    checkOutput("sh_done_stall", stall_req, 0);
    checkOutput("sh_done_wb_en", wb_en, 0);
    applyNop();
    tick();

    // SB to lane 1, immediate gnt
    $display("[TB] SB lane replication");
    applyStimulus(32'h0000_0011, 1'b0, 5'd0, 5'b00000, 3'b001, 32'h1234_565A);
    tick();
    checkOutput("sb_be", mem_be, 4'b0010);
    checkOutput("sb_wdata", mem_wdata, 32'h5A5A_5A5A);
    checkOutput("sb_addr", mem_addr, 32'h0000_0010);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    checkOutput("sb_done_stall", stall_req, 0);
    applyNop();
    tick();

    // Misaligned LW
    $display("[TB] misaligned LW");
    applyStimulus(32'h0000_0102, 1'b1, 5'd3, 5'b00100, 3'b000, 32'h0);
    checkOutput("mis_stall", stall_req, 0);
    checkOutput("mis_req", mem_req, 0);
    tick();
    applyNop();
    checkOutput("mis_exc", misalign_exc, 1);
    checkOutput("mis_wb_en", wb_en, 0);
    checkOutput("mis_req_after", mem_req, 0);
    tick();
    checkOutput("mis_exc_pulse", misalign_exc, 0);

    // LW with gnt withheld until timeout
    $display("[TB] LW timeout");
    applyStimulus(32'h0000_0300, 1'b1, 5'd4, 5'b00100, 3'b000, 32'h0);
    tick();
    req_cycles = 0;
    while (mem_req === 1'b1 && req_cycles < 400) begin
      req_cycles++;
      tick();
    end
    checkOutput("to_req_cycles", req_cycles, TIMEOUT);
    checkOutput("to_req_drop", mem_req, 0);
    checkOutput("to_stall_drop", stall_req, 0);
    applyNop();
    tick();
    checkOutput("to_bus_err", bus_err, 1);
    checkOutput("to_wb_en", wb_en, 0);
    checkOutput("to_idle_req", mem_req, 0);
    tick();
    checkOutput("to_bus_err_pulse", bus_err, 0);

    // Reset while waiting for read data, then LHU completes normally
    $display("[TB] reset in WAIT_R then LHU");
    applyStimulus(32'h0000_0402, 1'b1, 5'd9, 5'b10000, 3'b000, 32'h0);
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    checkOutput("rw_wait_stall", stall_req, 1);
    rst = 1'b1;
    #1;
    checkOutput("rw_rst_req", mem_req, 0);
    checkOutput("rw_rst_stall", stall_req, 0);
    checkOutput("rw_rst_wb_en", wb_en, 0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("lhu_idle_stall", stall_req, 1);
    tick();
    checkOutput("lhu_req", mem_req, 1);
    checkOutput("lhu_addr", mem_addr, 32'h0000_0400);
    mem_gnt = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h8765_4321;
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    checkOutput("lhu_wb_data", wb_data, 32'h0000_8765);
    checkOutput("lhu_wb_en", wb_en, 1);
    checkOutput("lhu_wb_addr", wb_addr, 9);
    applyNop();
    tick();
    checkOutput("lhu_after_wb_en", wb_en, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
